// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_pkg;

  localparam int   DATA_W  = 8;
  localparam logic TX_IDLE = 1'b1;
  // start + 8 data + parity-or-stop + up to two more stop/idle bits
  localparam int   FRAME_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Serial frame, LSB first. Slot 9 is even parity when enabled, otherwise the
  // first stop bit; everything above it is line-idle level.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [DATA_W-1:0] d,
                                                     input logic             par_en);
    build_frame = {TX_IDLE, TX_IDLE, (par_en ? ^d : TX_IDLE), d, 1'b0};
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial-side status, bundled between the drain engine and its
// surroundings. master = the transmitter, slave = FIFO / pin side.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic              tx_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              read_e;
  logic              tx;
  logic              busy;
  logic              frame_done;

  modport master (
    input  tx_en, fifo_empty, fifo_data,
    output read_e, tx, busy, frame_done
  );

  modport slave (
    output tx_en, fifo_empty, fifo_data,
    input  read_e, tx, busy, frame_done
  );
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period timer: bit_tick is high on the last clock of every bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign bit_tick = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // count within a bit period; back to zero on each boundary or when held in restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_cnt <= '0;
    else if (restart || bit_tick) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains an sfifo one byte at a time and serializes each byte as an 8N1 UART frame
// (optional even parity, 1 or 2 stop bits).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            reset,
  fifo_uart_tx_if.master bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-1:0] r_shift;
  logic [2:0]         r_bit_idx;
  logic               r_stop_idx;
  logic               r_read_e;
  logic               w_tick;
  logic               w_restart;
  logic               w_last_stop;
  logic               w_can_start;

  // The baud timer only runs while a bit is on the line.
  assign w_restart   = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);
  assign w_can_start = bus.tx_en && !bus.fifo_empty;
  assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .restart  (w_restart),
    .bit_tick (w_tick)
  );

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_can_start) w_state_nxt = FETCH;
      FETCH:   w_state_nxt = LOAD;
      LOAD:    w_state_nxt = START;
      START:   if (w_tick) w_state_nxt = DATA;
      DATA:    if (w_tick && (r_bit_idx == 3'd7))
                 w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (w_tick) w_state_nxt = STOP;
      STOP:    if (w_tick && w_last_stop)
                 w_state_nxt = w_can_start ? FETCH : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // registered pop strobe: high for exactly the FETCH cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_read_e <= 1'b0;
    else       r_read_e <= (w_state_nxt == FETCH);
  end

  // Whole frame is loaded at once and shifted out LSB first, so tx comes straight
  // from a flop; idle-level fill keeps the line high between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_shift <= '1;
    else if (r_state == LOAD)       r_shift <= build_frame(bus.fifo_data, PARITY_EN != 0);
    else if (w_tick && !w_restart)  r_shift <= {TX_IDLE, r_shift[FRAME_W-1:1]};
  end

  // data-bit and stop-bit position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else begin
      if ((r_state == DATA) && w_tick) r_bit_idx <= r_bit_idx + 3'd1;
      if ((r_state == STOP) && w_tick) r_stop_idx <= w_last_stop ? 1'b0 : r_stop_idx + 1'b1;
    end
  end

  assign bus.tx         = r_shift[0];
  assign bus.read_e     = r_read_e;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = (r_state == STOP) && w_tick && w_last_stop;

endmodule
